axi_slave_arbiter: RTL and testbench

AXI_SLAVE_ARBITER -- requirements
Module: axi_slave_arbiter

---
 rtl/axi_slave_arbiter_pkg.sv | 23 ++
 rtl/axi_slave_arbiter_if.sv | 55 +++++
 rtl/axi_slave_arbiter_rr_pick.sv | 43 ++++
 rtl/axi_slave_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_slave_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_slave_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and defaults for the AXI slave-side arbiter.
//   N_M_DEFAULT : default number of master ports competing for one slave
//   rd_state_t  : read-address channel FSM states
//   wr_state_t  : write-address/write-data FSM states
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  localparam int N_M_DEFAULT = 6;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ADDR = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_slave_arbiter_if.sv
// -----------------------------------------------------------------------------
// axi_slave_arbiter_if
// Bundles the per-master request vectors, slave ready inputs and the
// select / pop / valid outputs of the slave-side arbiter.
//   master modport : the arbiter view (drives selects, pops and valids)
//   slave  modport : the surrounding fabric view (drives requests, readies)
// Signal names keep their _i/_o suffixes as seen from the arbiter.
// -----------------------------------------------------------------------------
import axi_arb_pkg::*;

interface axi_slave_arbiter_if #(
  parameter int N_M = N_M_DEFAULT
) ();

  // Read address channel
  logic [N_M-1:0] ar_req_i;
  logic           s_arready_i;
  logic [N_M-1:0] ar_sel_o;
  logic [N_M-1:0] ar_pop_o;
  logic           s_arvalid_o;

  // Write address channel
  logic [N_M-1:0] aw_req_i;
  logic           s_awready_i;
  logic [N_M-1:0] aw_sel_o;
  logic [N_M-1:0] aw_pop_o;
  logic           s_awvalid_o;

  // Write data channel
  logic [N_M-1:0] w_req_i;
  logic           w_last_i;
  logic           s_wready_i;
  logic [N_M-1:0] w_sel_o;
  logic [N_M-1:0] w_pop_o;
  logic           s_wvalid_o;

  modport master (
    input  ar_req_i, s_arready_i,
    output ar_sel_o, ar_pop_o, s_arvalid_o,
    input  aw_req_i, s_awready_i,
    output aw_sel_o, aw_pop_o, s_awvalid_o,
    input  w_req_i, w_last_i, s_wready_i,
    output w_sel_o, w_pop_o, s_wvalid_o
  );

  modport slave (
    output ar_req_i, s_arready_i,
    input  ar_sel_o, ar_pop_o, s_arvalid_o,
    output aw_req_i, s_awready_i,
    input  aw_sel_o, aw_pop_o, s_awvalid_o,
    output w_req_i, w_last_i, s_wready_i,
    input  w_sel_o, w_pop_o, s_wvalid_o
  );

endinterface

// File: rtl/axi_slave_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: the winner is the lowest set request
// index at or above ptr_i, wrapping to the lowest set index overall.
//   req_i      : request vector
//   ptr_i      : current round-robin pointer (index)
//   grant_o    : one-hot winner (zero when no request)
//   next_ptr_o : winner index + 1, modulo N (zero when no request)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 6,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] next_ptr_o
);

  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick_src;
  logic [PW-1:0] nptr_acc [0:N];

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (PW'(gi) >= ptr_i);
  end

  // Requests at/above the pointer have priority; fall back to the full
  // vector when none exist (this is the wrap-around).
  assign hi_req   = req_i & hi_mask;
  assign pick_src = (|hi_req) ? hi_req : req_i;
  // Isolate the lowest set bit.
  assign grant_o  = pick_src & (~pick_src + N'(1));

  // One-hot to "index + 1 mod N" as an OR chain over the grant bits.
  assign nptr_acc[0] = '0;
  for (genvar gi = 0; gi < N; gi++) begin : g_nptr
    assign nptr_acc[gi+1] = nptr_acc[gi] | (grant_o[gi] ? PW'((gi + 1) % N) : '0);
  end
  assign next_ptr_o = nptr_acc[N];

endmodule

// File: rtl/axi_slave_arbiter.sv
// -----------------------------------------------------------------------------
// axi_slave_arbiter
// Slave-side arbiter for N_M AXI masters. The read-address channel and the
// write path (address + data burst) each run their own round-robin FSM.
//   AXI_CLK_i : clock
//   AXI_RST_i : asynchronous, active-high reset
//   bus       : axi_slave_arbiter_if.master
//     ar_req_i / s_arready_i  -> ar_sel_o, ar_pop_o, s_arvalid_o
//     aw_req_i / s_awready_i  -> aw_sel_o, aw_pop_o, s_awvalid_o
//     w_req_i, w_last_i, s_wready_i -> w_sel_o, w_pop_o, s_wvalid_o
// Selects are registered; valids and pops are combinational from the
// registered select and the live request/ready inputs.
// -----------------------------------------------------------------------------
import axi_arb_pkg::*;

module axi_slave_arbiter #(
  parameter int N_M = N_M_DEFAULT
) (
  input  logic              AXI_CLK_i,
  input  logic              AXI_RST_i,
  axi_slave_arbiter_if.master bus
);

  localparam int PW = (N_M > 1) ? $clog2(N_M) : 1;

  // ---------------------------------------------------------------------------
  // Read address channel
  // ---------------------------------------------------------------------------
  rd_state_t      rd_state_q;
  logic [N_M-1:0] ar_sel_q;
  logic [PW-1:0]  ar_ptr_q;
  logic [PW-1:0]  ar_nptr_q;   // winner+1 captured at grant, applied at handshake
  logic [N_M-1:0] ar_grant;
  logic [PW-1:0]  ar_grant_nptr;
  logic           ar_valid;
  logic           ar_hs;

  rr_pick #(.N(N_M), .PW(PW)) u_ar_pick (
    .req_i      (bus.ar_req_i),
    .ptr_i      (ar_ptr_q),
    .grant_o    (ar_grant),
    .next_ptr_o (ar_grant_nptr)
  );

  // A dropped request only lowers valid; the grant itself is held.
  assign ar_valid        = (rd_state_q == R_ADDR) && (|(bus.ar_req_i & ar_sel_q));
  assign ar_hs           = ar_valid && bus.s_arready_i;
  assign bus.ar_sel_o    = ar_sel_q;
  assign bus.s_arvalid_o = ar_valid;
  assign bus.ar_pop_o    = ar_sel_q & {N_M{ar_hs}};

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) begin
      rd_state_q <= R_IDLE;
      ar_sel_q   <= '0;
      ar_ptr_q   <= '0;
      ar_nptr_q  <= '0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (|bus.ar_req_i) begin
            ar_sel_q   <= ar_grant;
            ar_nptr_q  <= ar_grant_nptr;
            rd_state_q <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) begin
            ar_sel_q   <= '0;
            ar_ptr_q   <= ar_nptr_q;
            rd_state_q <= R_IDLE;
          end
        end
        default: begin
          ar_sel_q   <= '0;
          rd_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write address + data: only one burst in flight, so no AW arbitration
  // happens until the W_DATA phase has seen its WLAST beat.
  // ---------------------------------------------------------------------------
  wr_state_t      wr_state_q;
  logic [N_M-1:0] aw_sel_q;
  logic [N_M-1:0] w_sel_q;
  logic [PW-1:0]  aw_ptr_q;
  logic [PW-1:0]  aw_nptr_q;
  logic [N_M-1:0] aw_grant;
  logic [PW-1:0]  aw_grant_nptr;
  logic           aw_valid;
  logic           aw_hs;
  logic           w_valid;
  logic           w_hs;

  rr_pick #(.N(N_M), .PW(PW)) u_aw_pick (
    .req_i      (bus.aw_req_i),
    .ptr_i      (aw_ptr_q),
    .grant_o    (aw_grant),
    .next_ptr_o (aw_grant_nptr)
  );

  assign aw_valid        = (wr_state_q == W_ADDR) && (|(bus.aw_req_i & aw_sel_q));
  assign aw_hs           = aw_valid && bus.s_awready_i;
  assign bus.aw_sel_o    = aw_sel_q;
  assign bus.s_awvalid_o = aw_valid;
  assign bus.aw_pop_o    = aw_sel_q & {N_M{aw_hs}};

  // Data from a master is only forwarded once its address has been accepted.
  assign w_valid         = (wr_state_q == W_DATA) && (|(bus.w_req_i & w_sel_q));
  assign w_hs            = w_valid && bus.s_wready_i;
  assign bus.w_sel_o     = w_sel_q;
  assign bus.s_wvalid_o  = w_valid;
  assign bus.w_pop_o     = w_sel_q & {N_M{w_hs}};

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) begin
      wr_state_q <= W_IDLE;
      aw_sel_q   <= '0;
      w_sel_q    <= '0;
      aw_ptr_q   <= '0;
      aw_nptr_q  <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (|bus.aw_req_i) begin
            aw_sel_q   <= aw_grant;
            aw_nptr_q  <= aw_grant_nptr;
            wr_state_q <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_hs) begin
            w_sel_q    <= aw_sel_q;   // data phase follows the address owner
            aw_sel_q   <= '0;
            aw_ptr_q   <= aw_nptr_q;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs && bus.w_last_i) begin
            w_sel_q    <= '0;
            wr_state_q <= W_IDLE;
          end
        end
        default: begin
          aw_sel_q   <= '0;
          w_sel_q    <= '0;
          wr_state_q <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_slave_arbiter
// Directed scenarios followed by random stimulus; every cycle the DUT outputs
// are compared against a transaction-level reference model (owner/pointer
// bookkeeping with modulo arithmetic).
// -----------------------------------------------------------------------------
module tb_axi_slave_arbiter;

  localparam int N = 6;
  typedef logic [N-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slave_arbiter_if #(.N_M(N)) bus ();

  axi_slave_arbiter #(.N_M(N)) dut (
    .AXI_CLK_i (clk),
    .AXI_RST_i (rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: who owns each channel and where round-robin resumes.
  bit rd_busy;
  int rd_own;
  int ar_ptr;
  int wr_phase;   // 0 = waiting for AW, 1 = address offered, 2 = data burst
  int wr_own;
  int aw_ptr;

  // Observations from the last step, used by directed checks.
  vec_t last_ar_sel, last_aw_sel, last_w_sel, last_w_pop;
  logic last_arvalid, last_awvalid, last_wvalid;
  int   ar_pops[$];
  int   ar_pop_cyc[$];
  int   w_pop_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic vec_t bit_of(input int i);
    return vec_t'(1) << i;
  endfunction

  function automatic bit has(input vec_t v, input int i);
    return ((v >> i) & vec_t'(1)) != '0;
  endfunction

  function automatic int rr_winner(input vec_t req, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (has(req, idx)) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input vec_t v);
    for (int k = 0; k < N; k++) if (has(v, k)) return k;
    return -1;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // One clock cycle: compare outputs #1 after the inputs were applied (at the
  // falling edge), then advance the model to what the rising edge produces.
  task automatic step();
    vec_t e_ar_sel, e_ar_pop, e_aw_sel, e_aw_pop, e_w_sel, e_w_pop;
    bit   e_arv, e_awv, e_wv;
    int   w;
    #1;
    if (rst) begin
      rd_busy = 0; ar_ptr = 0; wr_phase = 0; aw_ptr = 0;
    end
    e_ar_sel = rd_busy ? bit_of(rd_own) : '0;
    e_arv    = rd_busy && has(bus.ar_req_i, rd_own);
    e_ar_pop = (e_arv && bus.s_arready_i) ? e_ar_sel : '0;
    e_aw_sel = (wr_phase == 1) ? bit_of(wr_own) : '0;
    e_awv    = (wr_phase == 1) && has(bus.aw_req_i, wr_own);
    e_aw_pop = (e_awv && bus.s_awready_i) ? e_aw_sel : '0;
    e_w_sel  = (wr_phase == 2) ? bit_of(wr_own) : '0;
    e_wv     = (wr_phase == 2) && has(bus.w_req_i, wr_own);
    e_w_pop  = (e_wv && bus.s_wready_i) ? e_w_sel : '0;

    check_eq("ar_sel",  32'(bus.ar_sel_o),    32'(e_ar_sel));
    check_eq("arvalid", 32'(bus.s_arvalid_o), 32'(e_arv));
    check_eq("ar_pop",  32'(bus.ar_pop_o),    32'(e_ar_pop));
    check_eq("aw_sel",  32'(bus.aw_sel_o),    32'(e_aw_sel));
    check_eq("awvalid", 32'(bus.s_awvalid_o), 32'(e_awv));
    check_eq("aw_pop",  32'(bus.aw_pop_o),    32'(e_aw_pop));
    check_eq("w_sel",   32'(bus.w_sel_o),     32'(e_w_sel));
    check_eq("wvalid",  32'(bus.s_wvalid_o),  32'(e_wv));
    check_eq("w_pop",   32'(bus.w_pop_o),     32'(e_w_pop));

    last_ar_sel  = bus.ar_sel_o;
    last_aw_sel  = bus.aw_sel_o;
    last_w_sel   = bus.w_sel_o;
    last_w_pop   = bus.w_pop_o;
    last_arvalid = bus.s_arvalid_o;
    last_awvalid = bus.s_awvalid_o;
    last_wvalid  = bus.s_wvalid_o;
    if (bus.ar_pop_o != '0) begin
      ar_pops.push_back(onehot_idx(bus.ar_pop_o));
      ar_pop_cyc.push_back(cyc);
    end
    if (bus.w_pop_o != '0) w_pop_cnt++;

    if (!rst) begin
      if (rd_busy) begin
        if (e_arv && bus.s_arready_i) begin
          $display("[%0d] AR handshake master %0d", cyc, rd_own);
          rd_busy = 0;
          ar_ptr  = (rd_own + 1) % N;
        end
      end else begin
        w = rr_winner(bus.ar_req_i, ar_ptr);
        if (w >= 0) begin rd_busy = 1; rd_own = w; end
      end
      case (wr_phase)
        0: begin
          w = rr_winner(bus.aw_req_i, aw_ptr);
          if (w >= 0) begin wr_phase = 1; wr_own = w; end
        end
        1: if (e_awv && bus.s_awready_i) begin
          $display("[%0d] AW handshake master %0d", cyc, wr_own);
          wr_phase = 2;
          aw_ptr   = (wr_own + 1) % N;
        end
        default: if (e_wv && bus.s_wready_i) begin
          $display("[%0d] W beat master %0d last=%0b", cyc, wr_own, bus.w_last_i);
          if (bus.w_last_i) wr_phase = 0;
        end
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.ar_req_i = '0; bus.s_arready_i = 1'b0;
    bus.aw_req_i = '0; bus.s_awready_i = 1'b0;
    bus.w_req_i  = '0; bus.w_last_i = 1'b0; bus.s_wready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    ar_pops.delete();
    ar_pop_cyc.delete();
    w_pop_cnt = 0;
  endtask

  initial begin
    int early;
    bit rdy_pat [5];
    idle_inputs();
    w_pop_cnt = 0;
    @(negedge clk);

    // Reset state, then two masters on AR with pointer at 0.
    do_reset();
    bus.ar_req_i = 6'b000101; bus.s_arready_i = 1'b1;
    repeat (6) step();
    check_eq("r028_count",  32'(ar_pops.size()), 32'd3);
    check_eq("r028_first",  32'(q_at(ar_pops, 0)), 32'd0);
    check_eq("r028_second", 32'(q_at(ar_pops, 1)), 32'd2);
    check_eq("r028_gap",    32'(q_at(ar_pop_cyc, 1) - q_at(ar_pop_cyc, 0)), 32'd2);
    check_eq("r028_wrap",   32'(q_at(ar_pops, 2)), 32'd0);

    // All six requesting: strict rotation 0..5,0 with one-cycle pops.
    do_reset();
    bus.ar_req_i = 6'b111111; bus.s_arready_i = 1'b1;
    repeat (14) step();
    check_eq("r029_count", 32'(ar_pops.size()), 32'd7);
    for (int i = 0; i < 7; i++) check_eq("r029_order", 32'(q_at(ar_pops, i)), 32'(i % N));
    for (int i = 1; i < 7; i++)
      check_eq("r029_pulse", 32'(q_at(ar_pop_cyc, i) - q_at(ar_pop_cyc, i - 1)), 32'd2);

    // Master3 4-beat burst with stalled ready; master1 must wait for WLAST.
    do_reset();
    bus.aw_req_i = 6'b001000; bus.s_awready_i = 1'b1; bus.w_req_i = 6'b001000;
    step();
    step();
    bus.aw_req_i = 6'b000010;
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    early = 0;
    for (int k = 0; k < 5; k++) begin
      bus.s_wready_i = rdy_pat[k];
      bus.w_last_i   = (k == 4);
      step();
      if (has(last_aw_sel, 1)) early++;
    end
    check_eq("r030_beats", 32'(w_pop_cnt), 32'd4);
    check_eq("r030_no_aw_during_burst", 32'(early), 32'd0);
    bus.s_wready_i = 1'b0; bus.w_last_i = 1'b0;
    step();
    check_eq("r030_w_idle_sel", 32'(last_w_sel), 32'd0);
    step();
    check_eq("r030_aw1_after", 32'(last_aw_sel), 32'(6'b000010));

    // W data waiting before any AW grant must stay blocked.
    do_reset();
    bus.w_req_i = 6'b000100; bus.s_wready_i = 1'b1;
    repeat (3) begin
      step();
      check_eq("r031_wvalid_blocked", 32'(last_wvalid), 32'd0);
      check_eq("r031_wpop_blocked",   32'(last_w_pop),  32'd0);
    end
    bus.aw_req_i = 6'b000100; bus.s_awready_i = 1'b1; bus.s_wready_i = 1'b0;
    step();
    step();
    bus.aw_req_i = '0;
    step();
    check_eq("r031_wvalid_open", 32'(last_wvalid), 32'd1);

    // Reset mid-burst after two beats.
    bus.s_wready_i = 1'b1;
    w_pop_cnt = 0;
    step();
    step();
    check_eq("r032_two_beats", 32'(w_pop_cnt), 32'd2);
    rst = 1'b1;
    step();
    check_eq("r032_wsel_zero",   32'(last_w_sel),  32'd0);
    check_eq("r032_wvalid_zero", 32'(last_wvalid), 32'd0);
    rst = 1'b0;
    idle_inputs();
    bus.aw_req_i = 6'b111111;
    step();
    step();
    check_eq("r032_ptr_reset", 32'(last_aw_sel), 32'(6'b000001));

    // Simultaneous AR and AW from master4.
    do_reset();
    bus.ar_req_i = 6'b010000; bus.aw_req_i = 6'b010000;
    step();
    step();
    check_eq("r033_arvalid", 32'(last_arvalid), 32'd1);
    check_eq("r033_awvalid", 32'(last_awvalid), 32'd1);

    // Random traffic including occasional mid-flight resets.
    do_reset();
    repeat (1500) begin
      bus.ar_req_i    = vec_t'($urandom);
      bus.aw_req_i    = vec_t'($urandom);
      bus.w_req_i     = vec_t'($urandom);
      bus.s_arready_i = ($urandom_range(0, 2) != 0);
      bus.s_awready_i = ($urandom_range(0, 2) != 0);
      bus.s_wready_i  = ($urandom_range(0, 2) != 0);
      bus.w_last_i    = ($urandom_range(0, 3) == 0);
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
